// File: rtl/md_unit_pkg.sv
// md_unit_pkg
//  Shared definitions for the multiply/divide unit:
//   - md_op_e       : 3-bit MD op codes carried with the instruction in E
//   - DEFAULT_*     : default latencies for multiply and divide
//   - md_result_t   : HI/LO result bundle produced by md_core
//   - is_arith_op() : true for the multi-cycle ops (mult/multu/div/divu)
package md_unit_pkg;

  typedef enum logic [2:0] {
    MDOP_NONE  = 3'd0,
    MDOP_MULT  = 3'd1,
    MDOP_MULTU = 3'd2,
    MDOP_DIV   = 3'd3,
    MDOP_DIVU  = 3'd4,
    MDOP_MTHI  = 3'd5,
    MDOP_MTLO  = 3'd6
  } md_op_e;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr_en;
  } md_result_t;

  function automatic logic is_arith_op(input md_op_e op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if
//  Bundles the E-stage side of the multiply/divide unit.
//   iop     : MD op of the instruction in E
//   ivalid  : instruction in E is real (not a bubble)
//   iflush  : flush this cycle; the op sampled this cycle is dropped
//   iA/iB   : forwarded rs/rt operands
//   iselhi  : 1 selects HI onto oRD, 0 selects LO
//   oRD     : combinational HI/LO read data
//   oMDbusy : busy flag for the hazard unit
//  master = pipeline side (drives the op), slave = md_unit.
interface md_unit_if;
  import md_unit_pkg::*;

  md_op_e      iop;
  logic        ivalid;
  logic        iflush;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iselhi;
  logic [31:0] oRD;
  logic        oMDbusy;

  modport master (
    output iop, ivalid, iflush, iA, iB, iselhi,
    input  oRD, oMDbusy
  );

  modport slave (
    input  iop, ivalid, iflush, iA, iB, iselhi,
    output oRD, oMDbusy
  );

endinterface

// File: rtl/md_unit_core.sv
// md_core
//  Purely combinational arithmetic for the MD unit, fed from the latched
//  operands and op held by md_unit.
//   op  : latched MD op
//   a/b : latched rs/rt operands
//   res : HI/LO values to commit and wr_en (low for divide-by-zero or a
//         non-arithmetic op, so HI/LO keep their old contents)
module md_core
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_result_t  res
);

  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;
  logic signed [31:0] s_a;
  logic signed [31:0] s_b;

  assign s_a    = $signed(a);
  assign s_b    = $signed(b);
  assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign u_prod = {32'd0, a} * {32'd0, b};

  always_comb begin
    res = '0;
    case (op)
      MDOP_MULT: begin
        res.hi    = s_prod[63:32];
        res.lo    = s_prod[31:0];
        res.wr_en = 1'b1;
      end
      MDOP_MULTU: begin
        res.hi    = u_prod[63:32];
        res.lo    = u_prod[31:0];
        res.wr_en = 1'b1;
      end
      MDOP_DIV: begin
        if (b == 32'd0) begin
          res.wr_en = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // The only signed quotient that overflows: wraps to the dividend.
          res.hi    = 32'd0;
          res.lo    = 32'h8000_0000;
          res.wr_en = 1'b1;
        end else begin
          res.lo    = s_a / s_b;
          res.hi    = s_a % s_b;
          res.wr_en = 1'b1;
        end
      end
      MDOP_DIVU: begin
        if (b != 32'd0) begin
          res.lo    = a / b;
          res.hi    = a % b;
          res.wr_en = 1'b1;
        end
      end
      default: begin
        res = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit
//  Multi-cycle multiply/divide unit in E holding the HI/LO registers.
//  mult/multu/div/divu run for a fixed number of edges and then commit;
//  mthi/mtlo write in one cycle. HI or LO is read combinationally.
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-high reset, clears all state
//   md    : md_unit_if.slave (op, operands, flush, read select, read data, busy)
//  Parameters:
//   MULT_CYCLES : edges from start to commit for mult/multu (>=1)
//   DIV_CYCLES  : edges from start to commit for div/divu (>=1)
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  md_op_e           op_q, op_d;

  logic             live;
  logic             go;
  md_result_t       core_res;

  // An op is live when it belongs to a real, unflushed instruction; it may
  // only act when no multi-cycle operation is in flight.
  assign live = md.ivalid & ~md.iflush;
  assign go   = live & (cnt_q == '0);

  md_core u_core (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (core_res)
  );

  // A running operation ignores new ops and flushes: it belongs to an older,
  // already committed instruction and must finish.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && core_res.wr_en) begin
        hi_d = core_res.hi;
        lo_d = core_res.lo;
      end
    end else if (go) begin
      case (md.iop)
        MDOP_MULT, MDOP_MULTU: begin
          a_d   = md.iA;
          b_d   = md.iB;
          op_d  = md.iop;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        MDOP_DIV, MDOP_DIVU: begin
          a_d   = md.iA;
          b_d   = md.iB;
          op_d  = md.iop;
          cnt_d = CNT_W'(DIV_CYCLES);
        end
        MDOP_MTHI: hi_d = md.iA;
        MDOP_MTLO: lo_d = md.iA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MDOP_NONE;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
    end
  end

  // Busy includes the start cycle itself so the dependent instruction in D
  // is already held while the op is being sampled. Reset forces it low even
  // if a live op is presented while reset is held.
  assign md.oMDbusy = ~reset & ((cnt_q != '0) | (live & is_arith_op(md.iop)));
  assign md.oRD     = reset ? 32'd0 : (md.iselhi ? hi_q : lo_q);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
//  Directed and randomized checks of md_unit against a behavioural HI/LO model.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MULT_LAT = DEFAULT_MULT_CYCLES;
  localparam int DIV_LAT  = DEFAULT_DIV_CYCLES;

  logic clk;
  logic reset;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES (MULT_LAT),
    .DIV_CYCLES  (DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Behavioural model of what one op does to HI/LO, using wide arithmetic.
  function automatic void modelExec(input md_op_e op, input logic [31:0] a,
                                    input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDOP_MULT: begin
        q = sa * sb;
        modelHi = q[63:32];
        modelLo = q[31:0];
      end
      MDOP_MULTU: begin
        p = ua * ub;
        modelHi = p[63:32];
        modelLo = p[31:0];
      end
      MDOP_DIV: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        modelLo = q[31:0];
        modelHi = r[31:0];
      end
      MDOP_DIVU: if (b != 32'd0) begin
        modelLo = a / b;
        modelHi = a % b;
      end
      MDOP_MTHI: modelHi = a;
      MDOP_MTLO: modelLo = a;
      default: ;
    endcase
  endfunction

  task automatic readRegs(output logic [31:0] h, output logic [31:0] l);
    bus.iselhi = 1'b1;
    #1;
    h = bus.oRD;
    bus.iselhi = 1'b0;
    #1;
    l = bus.oRD;
  endtask

  // Issues one op for one cycle, then idles until the unit is no longer busy.
  // flushAt >= 0 raises iflush (no op) in that busy cycle.
  task automatic applyStimulus(input md_op_e op, input logic [31:0] a,
                               input logic [31:0] b, input logic flush,
                               input int flushAt);
    int          busyCycles;
    int          guard;
    int          expBusy;
    logic [31:0] h, l;
    bit          arith;
    arith = (op == MDOP_MULT) || (op == MDOP_MULTU) ||
            (op == MDOP_DIV)  || (op == MDOP_DIVU);
    checkOutput("idle_before_issue", bus.oMDbusy, 1'b0);
    bus.iop    = op;
    bus.ivalid = 1'b1;
    bus.iflush = flush;
    bus.iA     = a;
    bus.iB     = b;
    #1;
    busyCycles = bus.oMDbusy ? 1 : 0;
    @(posedge clk);
    #1;
    bus.iop    = MDOP_NONE;
    bus.ivalid = 1'b0;
    bus.iflush = 1'b0;
    bus.iA     = $urandom;
    bus.iB     = $urandom;
    #1;
    guard = 0;
    while (bus.oMDbusy === 1'b1 && guard < 200) begin
      busyCycles++;
      if (guard == flushAt) begin
        bus.ivalid = 1'b1;
        bus.iflush = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.ivalid = 1'b0;
      bus.iflush = 1'b0;
      guard++;
      #1;
    end
    checkOutput("busy_bounded", guard < 200, 1'b1);
    if (arith && !flush)
      expBusy = ((op == MDOP_MULT || op == MDOP_MULTU) ? MULT_LAT : DIV_LAT) + 1;
    else
      expBusy = 0;
    checkOutput($sformatf("busy_len_op%0d", op), busyCycles, expBusy);
    if (!flush) modelExec(op, a, b);
    readRegs(h, l);
    checkOutput($sformatf("hi_op%0d", op), h, modelHi);
    checkOutput($sformatf("lo_op%0d", op), l, modelLo);
  endtask

  logic [31:0] rh, rl;
  logic [31:0] ra, rb;
  md_op_e      rop;

  initial begin
    reset      = 1'b1;
    bus.iop    = MDOP_NONE;
    bus.ivalid = 1'b0;
    bus.iflush = 1'b0;
    bus.iA     = 32'd0;
    bus.iB     = 32'd0;
    bus.iselhi = 1'b0;

    // Reset state, including a live op presented while reset is held.
    #2;
    checkOutput("reset_busy", bus.oMDbusy, 1'b0);
    readRegs(rh, rl);
    checkOutput("reset_hi", rh, 32'd0);
    checkOutput("reset_lo", rl, 32'd0);
    bus.iop    = MDOP_DIV;
    bus.ivalid = 1'b1;
    #1;
    checkOutput("reset_busy_gated", bus.oMDbusy, 1'b0);
    bus.iop    = MDOP_NONE;
    bus.ivalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Directed arithmetic cases.
    applyStimulus(MDOP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
    readRegs(rh, rl);
    checkOutput("mult_hi_const", rh, 32'hFFFF_FFFF);
    checkOutput("mult_lo_const", rl, 32'hFFFF_FFFA);

    applyStimulus(MDOP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
    readRegs(rh, rl);
    checkOutput("multu_hi_const", rh, 32'd2);
    checkOutput("multu_lo_const", rl, 32'hFFFF_FFFA);

    applyStimulus(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    readRegs(rh, rl);
    checkOutput("div_hi_const", rh, 32'hFFFF_FFFF);
    checkOutput("div_lo_const", rl, 32'hFFFF_FFFD);

    applyStimulus(MDOP_DIVU, 32'd7, 32'd2, 1'b0, -1);
    readRegs(rh, rl);
    checkOutput("divu_hi_const", rh, 32'd1);
    checkOutput("divu_lo_const", rl, 32'd3);

    applyStimulus(MDOP_MTHI, 32'h1234, 32'd0, 1'b0, -1);
    applyStimulus(MDOP_MTLO, 32'h1234, 32'd0, 1'b0, -1);
    applyStimulus(MDOP_DIV, 32'd5, 32'd0, 1'b0, -1);
    readRegs(rh, rl);
    checkOutput("divzero_hi_const", rh, 32'h1234);
    checkOutput("divzero_lo_const", rl, 32'h1234);

    applyStimulus(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    readRegs(rh, rl);
    checkOutput("divovf_hi_const", rh, 32'd0);
    checkOutput("divovf_lo_const", rl, 32'h8000_0000);

    // Back-to-back mthi/mtlo, never busy, visible the following cycle.
    @(posedge clk);
    #1;
    bus.iop    = MDOP_MTHI;
    bus.ivalid = 1'b1;
    bus.iA     = 32'hDEAD;
    #1;
    checkOutput("mthi_busy", bus.oMDbusy, 1'b0);
    @(posedge clk);
    #1;
    bus.iop    = MDOP_MTLO;
    bus.iA     = 32'hBEEF;
    bus.iselhi = 1'b1;
    #1;
    checkOutput("mtlo_busy", bus.oMDbusy, 1'b0);
    checkOutput("mthi_read", bus.oRD, 32'hDEAD);
    @(posedge clk);
    #1;
    bus.iop    = MDOP_NONE;
    bus.ivalid = 1'b0;
    bus.iselhi = 1'b0;
    #1;
    checkOutput("mtlo_read", bus.oRD, 32'hBEEF);
    checkOutput("mt_idle_busy", bus.oMDbusy, 1'b0);
    modelHi = 32'hDEAD;
    modelLo = 32'hBEEF;

    // Flushed mult never starts; flush during a running div does not stop it.
    applyStimulus(MDOP_MULT, 32'd9, 32'd9, 1'b1, -1);
    applyStimulus(MDOP_MTHI, 32'h0BAD_F00D, 32'd0, 1'b1, -1);
    applyStimulus(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 3);
    readRegs(rh, rl);
    checkOutput("flushdiv_lo_const", rl, 32'hFFFF_FFFD);

    // Asynchronous reset between edges in the middle of a mult.
    applyStimulus(MDOP_MTHI, 32'h5555_AAAA, 32'd0, 1'b0, -1);
    applyStimulus(MDOP_MTLO, 32'h0F0F_0F0F, 32'd0, 1'b0, -1);
    bus.iop    = MDOP_MULT;
    bus.ivalid = 1'b1;
    bus.iA     = 32'd1000;
    bus.iB     = 32'd1000;
    @(posedge clk);
    #1;
    bus.iop    = MDOP_NONE;
    bus.ivalid = 1'b0;
    @(posedge clk);
    #3;
    checkOutput("midmult_busy", bus.oMDbusy, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", bus.oMDbusy, 1'b0);
    readRegs(rh, rl);
    checkOutput("async_reset_hi", rh, 32'd0);
    checkOutput("async_reset_lo", rl, 32'd0);
    modelHi = 32'd0;
    modelLo = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("after_reset_busy", bus.oMDbusy, 1'b0);
    applyStimulus(MDOP_MULT, 32'h0001_0001, 32'hFFFF_0003, 1'b0, -1);

    // Random op stream with bubbles, flushes and corner operands.
    for (int i = 0; i < 40; i++) begin
      rop = md_op_e'($urandom_range(1, 6));
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 10)) - 32'd5; end
        2: begin ra = $urandom; rb = 32'd0; end
        default: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      endcase
      if ($urandom_range(0, 4) == 0) begin
        bus.iop    = rop;
        bus.ivalid = 1'b0;
        bus.iA     = ra;
        bus.iB     = rb;
        #1;
        checkOutput("bubble_busy", bus.oMDbusy, 1'b0);
        @(posedge clk);
        #1;
        bus.iop = MDOP_NONE;
        #1;
        checkOutput("bubble_after_busy", bus.oMDbusy, 1'b0);
      end
      applyStimulus(rop, ra, rb, ($urandom_range(0, 5) == 0), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
